cdb_writeback_arbiter: RTL and testbench

Write-back end of the register-file interface. It collects completed results from the functional units (ALU, load unit, …), buffers them in one FIFO per source, and round-robin arbitrates one result per cycle. The winning result drives the register-file write port (write_flag / Rd_write_NUM / writeData) and is broadcast with its tag on the common data bus to the reservation stations. It is the producer side of the write port that the decode stage's register file consumes.

---
 rtl/cdb_writeback_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback_arbiter.sv
// Write-back arbiter: one result FIFO per functional-unit source, round-robin
// selection of one head per cycle into a registered register-file write port
// that doubles as the common-data-bus broadcast.
// Optional feature macro: WB_BYPASS_EN (when all FIFOs are empty, the
// highest-priority accepted result skips its FIFO and loads the output directly).
module cdb_writeback_arbiter #(
    parameter int unsigned N_SIZE     = 16,
    parameter int unsigned N_REGISTER = 8,
    parameter int unsigned N_NUMBERS  = $clog2(N_REGISTER),
    parameter int unsigned N_SRC      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TAG_W      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC*N_NUMBERS-1:0] src_rd_num,
    input  logic [N_SRC*N_SIZE-1:0]    src_data,
    input  logic [N_SRC*TAG_W-1:0]     src_tag,
    output logic                       write_flag,
    output logic [N_NUMBERS-1:0]       Rd_write_NUM,
    output logic [N_SIZE-1:0]          writeData,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [N_SIZE-1:0]          cdb_data
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);

    typedef struct packed {
        logic [N_NUMBERS-1:0] rd;
        logic [N_SIZE-1:0]    data;
        logic [TAG_W-1:0]     tag;
    } entry_t;

    entry_t           mem_q    [N_SRC][FIFO_DEPTH];
    entry_t           mem_d    [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [N_SRC];
    logic [PTR_W-1:0] wr_ptr_d [N_SRC];
    logic [PTR_W-1:0] rd_ptr_q [N_SRC];
    logic [PTR_W-1:0] rd_ptr_d [N_SRC];
    logic [CNT_W-1:0] count_q  [N_SRC];
    logic [CNT_W-1:0] count_d  [N_SRC];
    logic [N_SRC-1:0] ready_q, ready_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    entry_t           out_q, out_d;
    logic             wr_flag_q, wr_flag_d;

    entry_t           src_in_c [N_SRC];
    logic [N_SRC-1:0] push_c;
    logic [N_SRC-1:0] not_empty_c;
    logic             grant_vld_c;
    logic [SRC_W-1:0] grant_idx_c;
    logic             byp_vld_c;
    logic [SRC_W-1:0] byp_idx_c;

    // Unpack source slices; a transfer happens when valid meets registered ready
    always_comb begin
        for (int unsigned i = 0; i < N_SRC; i++) begin
            src_in_c[i].rd   = src_rd_num[i*N_NUMBERS +: N_NUMBERS];
            src_in_c[i].data = src_data[i*N_SIZE +: N_SIZE];
            src_in_c[i].tag  = src_tag[i*TAG_W +: TAG_W];
            push_c[i]        = src_valid[i] & ready_q[i];
            not_empty_c[i]   = (count_q[i] != '0);
        end
    end

    // Round-robin grant: first non-empty FIFO after the last granted source
    always_comb begin
        logic [SRC_W-1:0] cand;
        cand        = '0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = SRC_W'((32'(rr_ptr_q) + k) % N_SRC);
            if (!grant_vld_c && not_empty_c[cand]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass pick: with every FIFO empty, the priority-order accepted source goes straight out
    always_comb begin
        logic [SRC_W-1:0] cand;
        cand      = '0;
        byp_vld_c = 1'b0;
        byp_idx_c = '0;
        if (not_empty_c == '0) begin
            for (int unsigned k = 1; k <= N_SRC; k++) begin
                cand = SRC_W'((32'(rr_ptr_q) + k) % N_SRC);
                if (!byp_vld_c && push_c[cand]) begin
                    byp_vld_c = 1'b1;
                    byp_idx_c = cand;
                end
            end
        end
    end
`else
    // Every result travels through its FIFO
    always_comb begin
        byp_vld_c = 1'b0;
        byp_idx_c = '0;
    end
`endif

    // Next state: pop the granted head into the output register, push accepted results
    always_comb begin
        logic pop;
        logic enq;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ready_d   = ready_q;
        rr_ptr_d  = rr_ptr_q;
        out_d     = out_q;
        wr_flag_d = 1'b0;
        pop       = 1'b0;
        enq       = 1'b0;

        if (grant_vld_c) begin
            out_d     = mem_q[grant_idx_c][rd_ptr_q[grant_idx_c]];
            wr_flag_d = 1'b1;
            rr_ptr_d  = grant_idx_c;
        end
        if (byp_vld_c) begin
            out_d     = src_in_c[byp_idx_c];
            wr_flag_d = 1'b1;
            rr_ptr_d  = byp_idx_c;
        end

        for (int unsigned i = 0; i < N_SRC; i++) begin
            pop = grant_vld_c && (grant_idx_c == SRC_W'(i));
            enq = push_c[i] && !(byp_vld_c && (byp_idx_c == SRC_W'(i)));
            if (pop) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end
            if (enq) begin
                mem_d[i][wr_ptr_q[i]] = src_in_c[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
            end
            count_d[i] = count_q[i] + CNT_W'(enq) - CNT_W'(pop);
            ready_d[i] = (count_d[i] < DEPTH_C);
        end
    end

    // Control and output state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '{default: '0};
            rd_ptr_q  <= '{default: '0};
            count_q   <= '{default: '0};
            ready_q   <= '1;
            rr_ptr_q  <= LAST_SRC;
            out_q     <= '0;
            wr_flag_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            rr_ptr_q  <= rr_ptr_d;
            out_q     <= out_d;
            wr_flag_q <= wr_flag_d;
        end
    end

    // FIFO storage; contents are meaningless while the counts are zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign src_ready    = ready_q;
    assign write_flag   = wr_flag_q;
    assign cdb_valid    = wr_flag_q;
    assign Rd_write_NUM = out_q.rd;
    assign writeData    = out_q.data;
    assign cdb_data     = out_q.data;
    assign cdb_tag      = out_q.tag;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: queue-based transaction model, directed
// scenarios plus a randomized stream. Honours WB_BYPASS_EN when defined.
module tb_cdb_writeback_arbiter;

    localparam int NS    = 16;
    localparam int NR    = 8;
    localparam int NN    = 3;
    localparam int NSRC  = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 3;
`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [NN-1:0] rd;
        logic [NS-1:0] data;
        logic [TW-1:0] tag;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC-1:0]      src_ready;
    logic [NSRC*NN-1:0]   src_rd_num;
    logic [NSRC*NS-1:0]   src_data;
    logic [NSRC*TW-1:0]   src_tag;
    logic                 write_flag;
    logic [NN-1:0]        Rd_write_NUM;
    logic [NS-1:0]        writeData;
    logic                 cdb_valid;
    logic [TW-1:0]        cdb_tag;
    logic [NS-1:0]        cdb_data;

    ent_t            drv_ent [NSRC];
    logic [NSRC-1:0] drv_valid;

    always_comb begin
        src_valid = drv_valid;
        for (int i = 0; i < NSRC; i++) begin
            src_rd_num[i*NN +: NN] = drv_ent[i].rd;
            src_data[i*NS +: NS]   = drv_ent[i].data;
            src_tag[i*TW +: TW]    = drv_ent[i].tag;
        end
    end

    always #5 clk = ~clk;

    cdb_writeback_arbiter #(
        .N_SIZE(NS), .N_REGISTER(NR), .N_NUMBERS(NN),
        .N_SRC(NSRC), .FIFO_DEPTH(DEPTH), .TAG_W(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_rd_num(src_rd_num), .src_data(src_data), .src_tag(src_tag),
        .write_flag(write_flag), .Rd_write_NUM(Rd_write_NUM), .writeData(writeData),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    // Stimulus queues per source and the reference model state
    ent_t            pend [NSRC][$];
    ent_t            mq   [NSRC][$];
    int              mptr;
    bit              last_acc [NSRC];
    logic            exp_flag;
    logic [NN-1:0]   exp_rd;
    logic [NS-1:0]   exp_data;
    logic [TW-1:0]   exp_tag;
    logic [NSRC-1:0] obs_ready, exp_ready;
    logic [NS-1:0]   wlog [$];
    logic [NN-1:0]   rlog [$];
    int              checks = 0;
    int              passes = 0;

    function automatic ent_t mk(input int rd, input int data, input int tag);
        ent_t e;
        e.rd   = NN'(rd);
        e.data = NS'(data);
        e.tag  = TW'(tag);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            mq[i].delete();
            pend[i].delete();
            last_acc[i] = 1'b0;
        end
        mptr     = NSRC - 1;
        exp_flag = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
        exp_tag  = '0;
    endtask

    // One clock edge of the write-back stage as a transaction-level model
    task automatic model_edge();
        bit   enq [NSRC];
        bit   all_empty;
        int   g;
        ent_t e;
        all_empty = 1'b1;
        g = -1;
        for (int i = 0; i < NSRC; i++) begin
            last_acc[i] = drv_valid[i] && (mq[i].size() < DEPTH);
            enq[i]      = last_acc[i];
            if (mq[i].size() != 0) all_empty = 1'b0;
        end
        for (int k = 1; k <= NSRC; k++) begin
            int c;
            c = (mptr + k) % NSRC;
            if (g < 0 && mq[c].size() != 0) g = c;
        end
        exp_flag = 1'b0;
        if (g >= 0) begin
            e        = mq[g].pop_front();
            exp_flag = 1'b1;
            exp_rd   = e.rd;
            exp_data = e.data;
            exp_tag  = e.tag;
            mptr     = g;
        end
`ifdef WB_BYPASS_EN
        else if (all_empty) begin
            for (int k = 1; k <= NSRC; k++) begin
                int c;
                c = (mptr + k) % NSRC;
                if (!exp_flag && enq[c]) begin
                    exp_flag = 1'b1;
                    exp_rd   = drv_ent[c].rd;
                    exp_data = drv_ent[c].data;
                    exp_tag  = drv_ent[c].tag;
                    mptr     = c;
                    enq[c]   = 1'b0;
                end
            end
        end
`endif
        for (int i = 0; i < NSRC; i++)
            if (enq[i]) mq[i].push_back(drv_ent[i]);
    endtask

    // Drive pending heads, sample ready before the edge, advance model and DUT
    task automatic cycle();
        for (int i = 0; i < NSRC; i++) begin
            drv_valid[i] = (pend[i].size() != 0);
            if (pend[i].size() != 0) drv_ent[i] = pend[i][0];
        end
        #0;
        obs_ready = src_ready;
        for (int i = 0; i < NSRC; i++) exp_ready[i] = (mq[i].size() < DEPTH);
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NSRC; i++)
            if (last_acc[i]) void'(pend[i].pop_front());
        if (write_flag === 1'b1) begin
            wlog.push_back(writeData);
            rlog.push_back(Rd_write_NUM);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        drv_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        wlog.delete();
        rlog.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (write_flag !== 1'b0 || cdb_valid !== 1'b0 || Rd_write_NUM !== '0 || writeData !== '0 ||
            cdb_tag !== '0 || cdb_data !== '0 || src_ready !== 2'b11)
            $display("FAIL reset_state: flag=%b rd=%0d data=%h tag=%0d ready=%b, expected 0/0/0/0/11",
                     write_flag, Rd_write_NUM, writeData, cdb_tag, src_ready);
        else passes++;
        for (int n = 0; n < 10; n++) begin
            cycle();
            checks++;
            if (write_flag !== 1'b0 || Rd_write_NUM !== '0 || writeData !== '0 || cdb_tag !== '0 ||
                obs_ready !== 2'b11)
                $display("FAIL reset_idle: cycle %0d flag=%b rd=%0d data=%h tag=%0d ready=%b, expected 0/0/0/0/11",
                         n, write_flag, Rd_write_NUM, writeData, cdb_tag, obs_ready);
            else passes++;
        end
    endtask

    task automatic test_single();
        int            lat;
        logic [NN-1:0] got_rd;
        logic [NS-1:0] got_data;
        logic [TW-1:0] got_tag;
        do_reset();
        lat = 0;
        got_rd = '0; got_data = '0; got_tag = '0;
        pend[0].push_back(mk(3, 16'h00A5, 1));
        for (int n = 1; n <= 8; n++) begin
            cycle();
            checks++;
            if (write_flag !== exp_flag || cdb_valid !== exp_flag || Rd_write_NUM !== exp_rd ||
                writeData !== exp_data || cdb_data !== exp_data || cdb_tag !== exp_tag)
                $display("FAIL single_out: flag=%b rd=%0d data=%h tag=%0d, expected flag=%b rd=%0d data=%h tag=%0d",
                         write_flag, Rd_write_NUM, writeData, cdb_tag, exp_flag, exp_rd, exp_data, exp_tag);
            else passes++;
            if (write_flag === 1'b1 && lat == 0) begin
                lat = n; got_rd = Rd_write_NUM; got_data = writeData; got_tag = cdb_tag;
            end
        end
        checks++;
        if (lat != LAT) $display("FAIL single_latency: got %0d edges, expected %0d", lat, LAT);
        else passes++;
        checks++;
        if (wlog.size() != 1 || got_rd !== 3'd3 || got_data !== 16'h00A5 || got_tag !== 3'd1)
            $display("FAIL single_write: writes=%0d rd=%0d data=%h tag=%0d, expected 1 write rd=3 data=00a5 tag=1",
                     wlog.size(), got_rd, got_data, got_tag);
        else passes++;
    endtask

    task automatic test_alternate();
        bit saw_drop;
        do_reset();
        saw_drop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pend[0].push_back(mk(k, 16'h0010 + k, 0));
            pend[1].push_back(mk(k, 16'h0020 + k, 1));
        end
        for (int n = 0; n < 24; n++) begin
            cycle();
            if (obs_ready != 2'b11) saw_drop = 1'b1;
            checks++;
            if (obs_ready !== exp_ready)
                $display("FAIL alt_ready: got %b, expected %b", obs_ready, exp_ready);
            else passes++;
            checks++;
            if (write_flag !== exp_flag || cdb_valid !== exp_flag || Rd_write_NUM !== exp_rd ||
                writeData !== exp_data || cdb_data !== exp_data || cdb_tag !== exp_tag)
                $display("FAIL alt_out: flag=%b rd=%0d data=%h tag=%0d, expected flag=%b rd=%0d data=%h tag=%0d",
                         write_flag, Rd_write_NUM, writeData, cdb_tag, exp_flag, exp_rd, exp_data, exp_tag);
            else passes++;
        end
        checks++;
        if (!saw_drop) $display("FAIL alt_backpressure: src_ready stayed 11, expected a drop");
        else passes++;
        checks++;
        if (wlog.size() != 16) $display("FAIL alt_count: got %0d writes, expected 16", wlog.size());
        else begin
            passes++;
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wlog[2*k] !== NS'(16'h0010 + k) || wlog[2*k+1] !== NS'(16'h0020 + k))
                    $display("FAIL alt_order: pair %0d got %h,%h expected %h,%h", k, wlog[2*k],
                             wlog[2*k+1], 16'h0010 + k, 16'h0020 + k);
                else passes++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit            saw_hold;
        logic [NS-1:0] s1 [$];
        do_reset();
        saw_hold = 1'b0;
        for (int k = 0; k < 12; k++) begin
            pend[0].push_back(mk(k % NR, 16'h0300 + k, 2));
            pend[1].push_back(mk((k + 1) % NR, 16'h0400 + k, 5));
        end
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (obs_ready[1] == 1'b0 && drv_valid[1] == 1'b1) saw_hold = 1'b1;
            checks++;
            if (obs_ready !== exp_ready)
                $display("FAIL bp_ready: got %b, expected %b", obs_ready, exp_ready);
            else passes++;
            checks++;
            if (write_flag !== exp_flag || Rd_write_NUM !== exp_rd || writeData !== exp_data ||
                cdb_tag !== exp_tag || cdb_valid !== exp_flag || cdb_data !== exp_data)
                $display("FAIL bp_out: flag=%b rd=%0d data=%h tag=%0d, expected flag=%b rd=%0d data=%h tag=%0d",
                         write_flag, Rd_write_NUM, writeData, cdb_tag, exp_flag, exp_rd, exp_data, exp_tag);
            else passes++;
        end
        checks++;
        if (!saw_hold) $display("FAIL bp_hold: src1 never saw ready=0 while valid, expected a stall");
        else passes++;
        foreach (wlog[j]) if (wlog[j][15:8] == 8'h04) s1.push_back(wlog[j]);
        checks++;
        if (s1.size() != 12 || wlog.size() != 24)
            $display("FAIL bp_count: src1 writes=%0d total=%0d, expected 12 and 24", s1.size(), wlog.size());
        else begin
            passes++;
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (s1[k] !== NS'(16'h0400 + k))
                    $display("FAIL bp_order: src1 write %0d got %h expected %h", k, s1[k], 16'h0400 + k);
                else passes++;
            end
        end
    endtask

    task automatic test_same_rd();
        do_reset();
        pend[0].push_back(mk(5, 16'h1111, 2));
        pend[1].push_back(mk(5, 16'h2222, 3));
        for (int n = 0; n < 6; n++) begin
            cycle();
            checks++;
            if (write_flag !== exp_flag || Rd_write_NUM !== exp_rd || writeData !== exp_data ||
                cdb_tag !== exp_tag)
                $display("FAIL samerd_out: flag=%b rd=%0d data=%h tag=%0d, expected flag=%b rd=%0d data=%h tag=%0d",
                         write_flag, Rd_write_NUM, writeData, cdb_tag, exp_flag, exp_rd, exp_data, exp_tag);
            else passes++;
        end
        checks++;
        if (wlog.size() != 2 || wlog[0] !== 16'h1111 || wlog[1] !== 16'h2222 ||
            rlog[0] !== 3'd5 || rlog[1] !== 3'd5)
            $display("FAIL samerd_seq: writes=%0d, expected two writes to r5: 1111 then 2222", wlog.size());
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        pend[0].push_back(mk(1, 16'h0AA0, 1));
        pend[0].push_back(mk(2, 16'h0AA1, 1));
        pend[1].push_back(mk(3, 16'h0BB0, 2));
        pend[1].push_back(mk(4, 16'h0BB1, 2));
        cycle();
        cycle();
        do_reset();
        checks++;
        if (write_flag !== 1'b0 || src_ready !== 2'b11)
            $display("FAIL rstmid_after: flag=%b ready=%b, expected 0 and 11", write_flag, src_ready);
        else passes++;
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++;
            if (write_flag !== 1'b0 || obs_ready !== 2'b11)
                $display("FAIL rstmid_idle: flag=%b ready=%b, expected 0 and 11", write_flag, obs_ready);
            else passes++;
        end
        pend[1].push_back(mk(6, 16'h5A5A, 4));
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++;
            if (write_flag !== exp_flag || Rd_write_NUM !== exp_rd || writeData !== exp_data ||
                cdb_tag !== exp_tag)
                $display("FAIL rstmid_out: flag=%b rd=%0d data=%h tag=%0d, expected flag=%b rd=%0d data=%h tag=%0d",
                         write_flag, Rd_write_NUM, writeData, cdb_tag, exp_flag, exp_rd, exp_data, exp_tag);
            else passes++;
        end
        checks++;
        if (wlog.size() != 1 || wlog[0] !== 16'h5A5A || rlog[0] !== 3'd6)
            $display("FAIL rstmid_write: writes=%0d, expected single write r6=5a5a", wlog.size());
        else passes++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 420; n++) begin
            if (n < 400) begin
                for (int i = 0; i < NSRC; i++)
                    if (pend[i].size() == 0 && $urandom_range(0, 3) != 0)
                        pend[i].push_back(mk(int'($urandom_range(0, NR - 1)), int'($urandom),
                                             int'($urandom_range(0, 7))));
            end
            cycle();
            checks++;
            if (obs_ready !== exp_ready)
                $display("FAIL rand_ready: cycle %0d got %b, expected %b", n, obs_ready, exp_ready);
            else passes++;
            checks++;
            if (write_flag !== exp_flag || cdb_valid !== exp_flag || Rd_write_NUM !== exp_rd ||
                writeData !== exp_data || cdb_data !== exp_data || cdb_tag !== exp_tag)
                $display("FAIL rand_out: cycle %0d flag=%b rd=%0d data=%h tag=%0d, expected flag=%b rd=%0d data=%h tag=%0d",
                         n, write_flag, Rd_write_NUM, writeData, cdb_tag, exp_flag, exp_rd, exp_data, exp_tag);
            else passes++;
        end
    endtask

    initial begin
        drv_valid = '0;
        for (int i = 0; i < NSRC; i++) drv_ent[i] = '0;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_same_rd();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule
